// File: rtl/seg_frame_scanner_pkg.sv
// seg_pkg: shared constants and types for the seg_frame_scanner display engine.
//   GLYPH_DASH / GLYPH_BLANK : special glyph codes (30 = '-', 31 = all segments off)
//   SEG_OFF                  : active-low cathode pattern with every segment dark
//   GLYPH_*                  : letter codes 16..29 of the shared glyph table
//   conv_state_t             : binary->BCD converter state
//   pow10()                  : elaboration-time 10**n for the overflow limit
package seg_pkg;

  localparam logic [4:0] GLYPH_DASH  = 5'd30;
  localparam logic [4:0] GLYPH_BLANK = 5'd31;
  localparam logic [7:0] SEG_OFF     = 8'hFF;

  localparam logic [4:0] GLYPH_H  = 5'd16;
  localparam logic [4:0] GLYPH_L  = 5'd17;
  localparam logic [4:0] GLYPH_P  = 5'd18;
  localparam logic [4:0] GLYPH_U  = 5'd19;
  localparam logic [4:0] GLYPH_R  = 5'd20;
  localparam logic [4:0] GLYPH_N  = 5'd21;
  localparam logic [4:0] GLYPH_O  = 5'd22;
  localparam logic [4:0] GLYPH_T  = 5'd23;
  localparam logic [4:0] GLYPH_Y  = 5'd24;
  localparam logic [4:0] GLYPH_J  = 5'd25;
  localparam logic [4:0] GLYPH_G  = 5'd26;
  localparam logic [4:0] GLYPH_HL = 5'd27;
  localparam logic [4:0] GLYPH_UL = 5'd28;
  localparam logic [4:0] GLYPH_CL = 5'd29;

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} conv_state_t;

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/seg_frame_scanner_glyph_rom.sv
// seg_glyph_rom: combinational glyph decoder, 5-bit code -> active-low segments.
//   code    in  5  glyph code (0-15 hex, 16-29 letters, 30 dash, 31 blank)
//   pattern out 8  cathodes, active-low, bit7 = DP (always off), bit0 = segment a
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (code)
      5'd0:    pattern = 8'hC0;
      5'd1:    pattern = 8'hF9;
      5'd2:    pattern = 8'hA4;
      5'd3:    pattern = 8'hB0;
      5'd4:    pattern = 8'h99;
      5'd5:    pattern = 8'h92;
      5'd6:    pattern = 8'h82;
      5'd7:    pattern = 8'hF8;
      5'd8:    pattern = 8'h80;
      5'd9:    pattern = 8'h90;
      5'd10:   pattern = 8'h88;
      5'd11:   pattern = 8'h83;
      5'd12:   pattern = 8'hC6;
      5'd13:   pattern = 8'hA1;
      5'd14:   pattern = 8'h86;
      5'd15:   pattern = 8'h8E;
      GLYPH_H:  pattern = 8'h89;
      GLYPH_L:  pattern = 8'hC7;
      GLYPH_P:  pattern = 8'h8C;
      GLYPH_U:  pattern = 8'hC1;
      GLYPH_R:  pattern = 8'hAF;
      GLYPH_N:  pattern = 8'hAB;
      GLYPH_O:  pattern = 8'hA3;
      GLYPH_T:  pattern = 8'h87;
      GLYPH_Y:  pattern = 8'h91;
      GLYPH_J:  pattern = 8'hE1;
      GLYPH_G:  pattern = 8'hC2;
      GLYPH_HL: pattern = 8'h8B;
      GLYPH_UL: pattern = 8'hE3;
      GLYPH_CL: pattern = 8'hA7;
      GLYPH_DASH:  pattern = 8'hBF;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_frame_scanner.sv
// seg_frame_scanner: multiplexed 7-segment display engine with a glyph frame
// buffer, per-digit blinking and a built-in binary->BCD converter.
// Optional feature: define SEG_LZB_EN to blank leading zeros of converted fields.
//   clk, rst    system clock, asynchronous active-high reset
//   msg_codes   5*DIGITS glyph codes (digit 0 = leftmost), msg_load latches them
//   num_value   value to convert, num_pos = buffer index of its MSD, num_load starts
//   blink_mask  digits that go dark during the blink-off phase
//   busy        converter active, num_done = one-cycle write-back pulse
//   seg_out     cathodes (active-low, bit7 DP), seg_en anodes (active-low, one-hot)
//
// Converter states:
//   state | meaning
//   IDLE  | waiting for num_load
//   SHIFT | double-dabble, one bit per cycle for NUM_W cycles
//   WRITE | BCD result valid, written into the frame buffer at the end of this cycle
module seg_frame_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25,
  parameter int NUM_W      = 9,
  parameter int NUM_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*DIGITS-1:0]   msg_codes,
  input  logic                  msg_load,
  input  logic [NUM_W-1:0]      num_value,
  input  logic [2:0]            num_pos,
  input  logic                  num_load,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  busy,
  output logic                  num_done,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     seg_en
);

  localparam int IDX_W     = $clog2(DIGITS);
  localparam int DIV_W     = $clog2(SCAN_DIV);
  localparam int FRM_W     = $clog2(BLINK_DIV + 1);
  localparam int CNT_W     = $clog2(NUM_W + 1);
  localparam int BCD_W     = 4 * NUM_DIGITS;
  localparam int NUM_LIMIT = pow10(NUM_DIGITS);

  logic [4:0]       frame_buf [DIGITS];
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic [FRM_W-1:0] frame_cnt;
  logic             blink_on;
  logic             div_wrap;
  logic             idx_wrap;
  logic [4:0]       glyph_code;
  logic [7:0]       glyph_pat;

  conv_state_t      state;
  logic [NUM_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       pos_q;
  logic             ovf_q;
  logic [4:0]       field_code [NUM_DIGITS];

  assign busy     = (state != IDLE);
  assign div_wrap = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign idx_wrap = (digit_idx == IDX_W'(DIGITS - 1));

  // Scan timing: digit dwell counter, digit index, blink frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) begin
        digit_idx <= idx_wrap ? '0 : digit_idx + 1'b1;
        if (idx_wrap) begin
          if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
            frame_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign glyph_code = frame_buf[digit_idx];

  seg_glyph_rom u_glyph_rom (
    .code    (glyph_code),
    .pattern (glyph_pat)
  );

  // Pins are registered so anodes and cathodes switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_en  <= '1;
      seg_out <= SEG_OFF;
    end else begin
      seg_en  <= ~(DIGITS'(1) << digit_idx);
      seg_out <= (!blink_on && blink_mask[digit_idx]) ? SEG_OFF : glyph_pat;
    end
  end

  // Double-dabble add-3 correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      bit_cnt  <= '0;
      pos_q    <= '0;
      ovf_q    <= 1'b0;
      num_done <= 1'b0;
    end else begin
      num_done <= 1'b0;
      case (state)
        IDLE: begin
          if (num_load) begin
            state   <= SHIFT;
            bin_sr  <= num_value;
            bcd_sr  <= '0;
            bit_cnt <= CNT_W'(NUM_W);
            pos_q   <= num_pos;
            ovf_q   <= (32'(num_value) >= 32'(NUM_LIMIT));
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == CNT_W'(1)) state <= WRITE;
        end
        WRITE: begin
          state    <= IDLE;
          num_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Field glyphs, MSD first; overflow turns the whole field into dashes.
`ifdef SEG_LZB_EN
  logic lead_zero;
`endif
  always_comb begin
`ifdef SEG_LZB_EN
    lead_zero = 1'b1;
`endif
    for (int j = 0; j < NUM_DIGITS; j++) begin
      field_code[j] = ovf_q ? GLYPH_DASH : {1'b0, bcd_sr[4*(NUM_DIGITS-1-j) +: 4]};
`ifdef SEG_LZB_EN
      if (bcd_sr[4*(NUM_DIGITS-1-j) +: 4] != 4'd0) lead_zero = 1'b0;
      // The units digit stays visible so a zero value still shows "0".
      if (!ovf_q && lead_zero && (j != NUM_DIGITS - 1)) field_code[j] = GLYPH_BLANK;
`endif
    end
  end

  // A message load and a converter write on the same edge: field digits win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) frame_buf[i] <= GLYPH_BLANK;
    end else begin
      if (msg_load) begin
        for (int i = 0; i < DIGITS; i++) frame_buf[i] <= msg_codes[5*i +: 5];
      end
      if (state == WRITE) begin
        for (int j = 0; j < NUM_DIGITS; j++) begin
          if (int'(pos_q) + j < DIGITS) frame_buf[IDX_W'(int'(pos_q) + j)] <= field_code[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_frame_scanner.sv
module tb_seg_frame_scanner;

  localparam int DIGITS    = 8;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int NUM_W     = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] msg_codes = '0;
  logic        msg_load = 1'b0;
  logic [8:0]  num_value = '0;
  logic [2:0]  num_pos = '0;
  logic        num_load = 1'b0;
  logic [7:0]  blink_mask = '0;

  logic       busy0, done0, busy1, done1;
  logic [7:0] seg_out0, seg_out1, seg_en0, seg_en1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seg_frame_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV),
                      .NUM_W(NUM_W), .NUM_DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .msg_codes(msg_codes), .msg_load(msg_load),
    .num_value(num_value), .num_pos(num_pos), .num_load(num_load),
    .blink_mask(blink_mask), .busy(busy0), .num_done(done0),
    .seg_out(seg_out0), .seg_en(seg_en0));

  seg_frame_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV),
                      .NUM_W(NUM_W), .NUM_DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .msg_codes(msg_codes), .msg_load(msg_load),
    .num_value(num_value), .num_pos(num_pos), .num_load(num_load),
    .blink_mask(blink_mask), .busy(busy1), .num_done(done1),
    .seg_out(seg_out1), .seg_en(seg_en1));

  function automatic logic [7:0] tb_glyph(input logic [4:0] c);
    case (c)
      5'd0: return 8'hC0;  5'd1: return 8'hF9;  5'd2: return 8'hA4;  5'd3: return 8'hB0;
      5'd4: return 8'h99;  5'd5: return 8'h92;  5'd6: return 8'h82;  5'd7: return 8'hF8;
      5'd8: return 8'h80;  5'd9: return 8'h90;  5'd10: return 8'h88; 5'd11: return 8'h83;
      5'd12: return 8'hC6; 5'd13: return 8'hA1; 5'd14: return 8'h86; 5'd15: return 8'h8E;
      5'd16: return 8'h89; 5'd17: return 8'hC7; 5'd18: return 8'h8C; 5'd19: return 8'hC1;
      5'd20: return 8'hAF; 5'd21: return 8'hAB; 5'd22: return 8'hA3; 5'd23: return 8'h87;
      5'd24: return 8'h91; 5'd25: return 8'hE1; 5'd26: return 8'hC2; 5'd27: return 8'h8B;
      5'd28: return 8'hE3; 5'd29: return 8'hA7; 5'd30: return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  // Reference model: cycle count since reset drives scan/blink arithmetically;
  // conversions are tracked as (start edge, value, position) transactions.
  int         m_cyc = 0;
  int         m_end = 0;
  int         m_val = 0;
  int         m_pos = 0;
  bit         m_act = 1'b0;
  logic [4:0] mbuf [2][DIGITS];
  logic [17:0] exp_v [2];
  int         nd_of [2] = '{3, 2};

  always @(posedge clk or posedge rst) begin
    int idx, frames, p10, pw, d, code;
    bit on, fin, ovf;
    logic [7:0] en, out;
`ifdef SEG_LZB_EN
    bit lead;
`endif
    if (rst) begin
      m_cyc = 0;
      m_act = 1'b0;
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < DIGITS; i++) mbuf[u][i] = 5'd31;
        exp_v[u] = {8'hFF, 8'hFF, 2'b00};
      end
    end else begin
      idx    = (m_cyc / SCAN_DIV) % DIGITS;
      frames = m_cyc / (SCAN_DIV * DIGITS);
      on     = ((frames / BLINK_DIV) % 2) == 0;
      fin    = m_act && (m_cyc == m_end);
      for (int u = 0; u < 2; u++) begin
        en  = ~(8'd1 << idx);
        out = (!on && blink_mask[idx]) ? 8'hFF : tb_glyph(mbuf[u][idx]);
        if (msg_load) for (int i = 0; i < DIGITS; i++) mbuf[u][i] = msg_codes[5*i +: 5];
        if (fin) begin
          p10 = 1;
          for (int k = 0; k < nd_of[u]; k++) p10 = p10 * 10;
          ovf = m_val >= p10;
          pw  = p10;
`ifdef SEG_LZB_EN
          lead = 1'b1;
`endif
          for (int j = 0; j < nd_of[u]; j++) begin
            pw   = pw / 10;
            d    = (m_val / pw) % 10;
            code = ovf ? 30 : d;
`ifdef SEG_LZB_EN
            if (d != 0) lead = 1'b0;
            if (!ovf && lead && j < nd_of[u] - 1) code = 31;
`endif
            if (m_pos + j < DIGITS) mbuf[u][m_pos + j] = 5'(code);
          end
        end
        exp_v[u] = {en, out, 1'b0, fin};
      end
      if (fin) m_act = 1'b0;
      else if (!m_act && num_load) begin
        m_act = 1'b1;
        m_end = m_cyc + NUM_W + 1;
        m_val = int'(num_value);
        m_pos = int'(num_pos);
      end
      for (int u = 0; u < 2; u++) exp_v[u][1] = m_act;
      m_cyc++;
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if ({seg_en0, seg_out0, busy0, done0} !== {8'hFF, 8'hFF, 2'b00}) begin
        tests_failed++;
        $display("FAIL reset_state got=%h want=%h", {seg_en0, seg_out0, busy0, done0}, {8'hFF, 8'hFF, 2'b00});
      end
      tests_run++;
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({seg_en0, seg_out0, busy0, done0} !== exp_v[0]) begin
        tests_failed++;
        $display("FAIL reset_scan i=%0d got=%h want=%h", i, {seg_en0, seg_out0, busy0, done0}, exp_v[0]);
      end
      if (seg_out0 !== 8'hFF) begin
        tests_failed++;
        $display("FAIL reset_blank i=%0d got=%h want=ff", i, seg_out0);
      end
      tests_run += 2;
    end
  endtask

  task automatic test_msg_load();
    for (int i = 0; i < DIGITS; i++) msg_codes[5*i +: 5] = 5'(i);
    for (int i = 0; i < 80; i++) begin
      msg_load = (i == 0) || (i == 45);
      if (i == 45) for (int k = 0; k < DIGITS; k++) msg_codes[5*k +: 5] = 5'($urandom_range(0, 31));
      @(negedge clk);
      if ({seg_en0, seg_out0, busy0, done0} !== exp_v[0]) begin
        tests_failed++;
        $display("FAIL msg_load u0 i=%0d got=%h want=%h", i, {seg_en0, seg_out0, busy0, done0}, exp_v[0]);
      end
      if ({seg_en1, seg_out1, busy1, done1} !== exp_v[1]) begin
        tests_failed++;
        $display("FAIL msg_load u1 i=%0d got=%h want=%h", i, {seg_en1, seg_out1, busy1, done1}, exp_v[1]);
      end
      tests_run += 2;
      if (i > 2 && i < 45 && seg_en0[3] === 1'b0) begin
        if (seg_out0 !== 8'hB0) begin
          tests_failed++;
          $display("FAIL msg_digit3 got=%h want=b0", seg_out0);
        end
        tests_run++;
      end
    end
    msg_load = 1'b0;
  endtask

  // One conversion; also measures busy length and num_done pulses on the 3-digit unit.
  task automatic test_convert(input int value, input int pos, input int extra_load, input string tag);
    int busy_cnt, done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    num_value = 9'(value);
    num_pos   = 3'(pos);
    for (int i = 0; i < NUM_W + 6; i++) begin
      num_load = (i == 0) || (i == extra_load);
      if (i == extra_load) num_value = 9'($urandom_range(0, 511));
      @(negedge clk);
      if ({seg_en0, seg_out0, busy0, done0} !== exp_v[0]) begin
        tests_failed++;
        $display("FAIL %s u0 i=%0d got=%h want=%h", tag, i, {seg_en0, seg_out0, busy0, done0}, exp_v[0]);
      end
      if ({seg_en1, seg_out1, busy1, done1} !== exp_v[1]) begin
        tests_failed++;
        $display("FAIL %s u1 i=%0d got=%h want=%h", tag, i, {seg_en1, seg_out1, busy1, done1}, exp_v[1]);
      end
      tests_run += 2;
      busy_cnt += int'(busy0);
      done_cnt += int'(done0);
    end
    num_load = 1'b0;
    if (busy_cnt != NUM_W + 1) begin
      tests_failed++;
      $display("FAIL %s busy_len got=%0d want=%0d", tag, busy_cnt, NUM_W + 1);
    end
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s done_pulses got=%0d want=1", tag, done_cnt);
    end
    tests_run += 2;
    // Let the new digits scan past the pins and be compared by the model.
    for (int i = 0; i < SCAN_DIV * DIGITS; i++) begin
      @(negedge clk);
      if ({seg_en0, seg_out0} !== exp_v[0][17:2] || {seg_en1, seg_out1} !== exp_v[1][17:2]) begin
        tests_failed++;
        $display("FAIL %s frame i=%0d got=%h/%h want=%h/%h", tag, i, {seg_en0, seg_out0},
                 {seg_en1, seg_out1}, exp_v[0][17:2], exp_v[1][17:2]);
      end
      tests_run++;
    end
  endtask

  task automatic test_msg_on_write();
    for (int k = 0; k < DIGITS; k++) msg_codes[5*k +: 5] = 5'($urandom_range(16, 29));
    num_value = 9'd42;
    num_pos   = 3'd2;
    for (int i = 0; i < NUM_W + 10; i++) begin
      num_load = (i == 0);
      msg_load = (i == NUM_W + 1);
      @(negedge clk);
      if ({seg_en0, seg_out0, busy0, done0} !== exp_v[0]) begin
        tests_failed++;
        $display("FAIL msg_on_write u0 i=%0d got=%h want=%h", i, {seg_en0, seg_out0, busy0, done0}, exp_v[0]);
      end
      if ({seg_en1, seg_out1, busy1, done1} !== exp_v[1]) begin
        tests_failed++;
        $display("FAIL msg_on_write u1 i=%0d got=%h want=%h", i, {seg_en1, seg_out1, busy1, done1}, exp_v[1]);
      end
      tests_run += 2;
    end
    num_load = 1'b0;
    msg_load = 1'b0;
  endtask

  task automatic test_blink(input logic [7:0] mask);
    int dark, lit;
    dark = 0;
    lit  = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < DIGITS; k++) msg_codes[5*k +: 5] = 5'(k);
    blink_mask = mask;
    for (int i = 0; i < 4 * BLINK_DIV * SCAN_DIV * DIGITS + 4; i++) begin
      msg_load = (i == 0);
      @(negedge clk);
      if ({seg_en0, seg_out0, busy0, done0} !== exp_v[0]) begin
        tests_failed++;
        $display("FAIL blink u0 i=%0d got=%h want=%h", i, {seg_en0, seg_out0, busy0, done0}, exp_v[0]);
      end
      if ({seg_en1, seg_out1, busy1, done1} !== exp_v[1]) begin
        tests_failed++;
        $display("FAIL blink u1 i=%0d got=%h want=%h", i, {seg_en1, seg_out1, busy1, done1}, exp_v[1]);
      end
      tests_run += 2;
      if (i > 2 && seg_en0[0] === 1'b0) begin
        if (seg_out0 === 8'hFF) dark++;
        else lit++;
      end
    end
    msg_load = 1'b0;
    if (mask[0] && (dark != 2 * BLINK_DIV * SCAN_DIV || lit < BLINK_DIV * SCAN_DIV)) begin
      tests_failed++;
      $display("FAIL blink_digit0 dark=%0d lit=%0d want dark=%0d", dark, lit, 2 * BLINK_DIV * SCAN_DIV);
    end
    tests_run++;
    blink_mask = '0;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    num_value = 9'd123;
    num_pos   = 3'd0;
    num_load  = 1'b1;
    @(negedge clk);
    num_load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    if ({busy0, done0, seg_en0, seg_out0} !== {2'b00, 8'hFF, 8'hFF}) begin
      tests_failed++;
      $display("FAIL reset_mid_state got=%h want=%h", {busy0, done0, seg_en0, seg_out0}, {2'b00, 8'hFF, 8'hFF});
    end
    tests_run++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * NUM_W + SCAN_DIV * DIGITS; i++) begin
      @(negedge clk);
      if ({seg_en0, seg_out0, busy0, done0} !== exp_v[0]) begin
        tests_failed++;
        $display("FAIL reset_mid u0 i=%0d got=%h want=%h", i, {seg_en0, seg_out0, busy0, done0}, exp_v[0]);
      end
      if (seg_out0 !== 8'hFF) begin
        tests_failed++;
        $display("FAIL reset_mid_blank i=%0d got=%h want=ff", i, seg_out0);
      end
      tests_run += 2;
      dones += int'(done0) + int'(done1) + int'(busy0);
    end
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_activity got=%0d want=0", dones);
    end
    tests_run++;
  endtask

  initial begin
    test_reset();
    test_msg_load();
    test_convert(255, 5, -1, "conv_255");
    test_convert(7, 0, -1, "conv_7");
    test_convert(0, 3, -1, "conv_0");
    test_convert(100, 1, -1, "conv_100");
    test_convert(99, 7, 4, "conv_pos7_reload");
    for (int r = 0; r < 6; r++)
      test_convert($urandom_range(0, 511), $urandom_range(0, 7), -1, "conv_rand");
    test_msg_on_write();
    test_blink(8'h01);
    test_blink(8'($urandom_range(0, 255)));
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
